// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the ATM cash dispenser: FSM state encoding and
// default note values.
// ---------------------------------------------------------------------------
package atm_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_CHECK_ENC = 2'd1;
    localparam logic [1:0] ST_PAY_ENC   = 2'd2;
    localparam logic [1:0] ST_GAP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_CHECK = ST_CHECK_ENC,
        ST_PAY   = ST_PAY_ENC,
        ST_GAP   = ST_GAP_ENC
    } state_t;

    localparam int DEF_NOTE_BIG   = 10;
    localparam int DEF_NOTE_SMALL = 1;
    localparam int DEF_NOTE_GAP   = 2;

endpackage

// File: rtl/atm_note_planner.sv
// ---------------------------------------------------------------------------
// atm_note_planner
// Combinational feasibility check and note split for a withdrawal.
// Greedy: as many big notes as the amount and reservoir allow, the
// remainder in small notes.
// Ports:
//   i_amt_r      requested amount (registered copy)
//   i_big_cnt    big notes in reservoir
//   i_small_cnt  small notes in reservoir
//   o_ok         amount is non-zero and payable from the reservoir
//   o_use_big    big notes to pay
//   o_use_small  small notes to pay (meaningful only when o_ok)
// ---------------------------------------------------------------------------
module atm_note_planner #(
    parameter int AMT_W      = 16,
    parameter int CNT_W      = 8,
    parameter int NOTE_BIG   = 10,
    parameter int NOTE_SMALL = 1
) (
    input  logic [AMT_W-1:0] i_amt_r,
    input  logic [CNT_W-1:0] i_big_cnt,
    input  logic [CNT_W-1:0] i_small_cnt,
    output logic             o_ok,
    output logic [CNT_W-1:0] o_use_big,
    output logic [CNT_W-1:0] o_use_small
);

    localparam int PW = AMT_W + CNT_W;

    logic [PW-1:0]    w_amt_ext;
    logic [PW-1:0]    w_q_big;
    logic [CNT_W-1:0] w_use_big;
    logic [PW-1:0]    w_rem;
    logic [PW-1:0]    w_rem_q;
    logic [PW-1:0]    w_rem_m;

    always_comb begin
        w_amt_ext = PW'(i_amt_r);
        w_q_big   = w_amt_ext / PW'(NOTE_BIG);
        // min() bounds the result by big_cnt, so it always fits CNT_W
        w_use_big = (w_q_big < PW'(i_big_cnt)) ? w_q_big[CNT_W-1:0] : i_big_cnt;
        // use_big*NOTE_BIG <= amount, so this cannot underflow
        w_rem     = w_amt_ext - PW'(w_use_big) * PW'(NOTE_BIG);
        w_rem_q   = w_rem / PW'(NOTE_SMALL);
        w_rem_m   = w_rem % PW'(NOTE_SMALL);
    end

    assign o_ok        = (w_rem_m == '0) && (w_rem_q <= PW'(i_small_cnt)) && (i_amt_r != '0);
    assign o_use_big   = w_use_big;
    assign o_use_small = w_rem_q[CNT_W-1:0];

endmodule

// File: rtl/atm_cash_dispenser.sv
// ---------------------------------------------------------------------------
// atm_cash_dispenser
// Responder end of the ATM withdrawal interface. Accepts a withdrawal,
// checks it against the note reservoir and either rejects it
// (not_enough_cash) or pays it out one note per PAY cycle, big notes first,
// with NOTE_GAP idle cycles after every note, then pulses done.
// Ports:
//   clock, reset                 clock / async active-high reset
//   req_valid/req_amount/req_ready  withdrawal request handshake
//   load_valid/load_big/load_small  reservoir refill (IDLE only)
//   note_big/note_small          one-cycle eject pulses
//   done/not_enough_cash         one-cycle completion pulses
//   busy                         FSM not idle
//   cash_total                   reservoir value, truncated to AMT_W
// ---------------------------------------------------------------------------
module atm_cash_dispenser
    import atm_pkg::*;
#(
    parameter int AMT_W      = 16,
    parameter int CNT_W      = 8,
    parameter int NOTE_BIG   = DEF_NOTE_BIG,
    parameter int NOTE_SMALL = DEF_NOTE_SMALL,
    parameter int NOTE_GAP   = DEF_NOTE_GAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] load_big,
    input  logic [CNT_W-1:0] load_small,
    output logic             note_big,
    output logic             note_small,
    output logic             done,
    output logic             not_enough_cash,
    output logic             busy,
    output logic [AMT_W-1:0] cash_total
);

    localparam int GW = $clog2(NOTE_GAP + 1);

    state_t           r_state, w_next_state;
    logic [AMT_W-1:0] r_amt;
    logic [CNT_W-1:0] r_big_cnt, r_small_cnt;
    logic [CNT_W-1:0] r_big_left, r_small_left;
    logic [GW-1:0]    r_gap;
    logic             r_done, r_nec;

    logic             w_ok;
    logic [CNT_W-1:0] w_use_big, w_use_small;
    logic [CNT_W:0]   w_sum_big, w_sum_small;
    logic             w_more;

    atm_note_planner #(
        .AMT_W      (AMT_W),
        .CNT_W      (CNT_W),
        .NOTE_BIG   (NOTE_BIG),
        .NOTE_SMALL (NOTE_SMALL)
    ) u_planner (
        .i_amt_r     (r_amt),
        .i_big_cnt   (r_big_cnt),
        .i_small_cnt (r_small_cnt),
        .o_ok        (w_ok),
        .o_use_big   (w_use_big),
        .o_use_small (w_use_small)
    );

    assign w_sum_big   = {1'b0, r_big_cnt} + {1'b0, load_big};
    assign w_sum_small = {1'b0, r_small_cnt} + {1'b0, load_small};
    assign w_more      = (r_big_left != '0) || (r_small_left != '0);

    // Modular arithmetic: computing in AMT_W gives the same low bits as a
    // wide product truncated afterwards.
    assign cash_total = AMT_W'(r_big_cnt) * AMT_W'(NOTE_BIG)
                      + AMT_W'(r_small_cnt) * AMT_W'(NOTE_SMALL);

    // ---- FSM state register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // ---- FSM next state and outputs ----
    always_comb begin
        w_next_state    = r_state;
        req_ready       = 1'b0;
        busy            = 1'b1;
        note_big        = 1'b0;
        note_small      = 1'b0;
        done            = r_done;
        not_enough_cash = r_nec;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) w_next_state = ST_CHECK;
            end
            ST_CHECK: w_next_state = w_ok ? ST_PAY : ST_IDLE;
            ST_PAY: begin
                note_big     = (r_big_left != '0);
                note_small   = (r_big_left == '0);
                w_next_state = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap == '0) w_next_state = w_more ? ST_PAY : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---- datapath: reservoir, plan, gap timer, completion pulses ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_amt        <= '0;
            r_big_cnt    <= '0;
            r_small_cnt  <= '0;
            r_big_left   <= '0;
            r_small_left <= '0;
            r_gap        <= '0;
            r_done       <= 1'b0;
            r_nec        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_nec  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_valid) begin
                        r_big_cnt   <= w_sum_big[CNT_W]   ? '1 : w_sum_big[CNT_W-1:0];
                        r_small_cnt <= w_sum_small[CNT_W] ? '1 : w_sum_small[CNT_W-1:0];
                    end
                    if (req_valid) r_amt <= req_amount;
                end
                ST_CHECK: begin
                    r_nec <= !w_ok;
                    if (w_ok) begin
                        r_big_left   <= w_use_big;
                        r_small_left <= w_use_small;
                    end
                end
                ST_PAY: begin
                    if (r_big_left != '0) begin
                        r_big_cnt  <= r_big_cnt - 1'b1;
                        r_big_left <= r_big_left - 1'b1;
                    end else begin
                        r_small_cnt  <= r_small_cnt - 1'b1;
                        r_small_left <= r_small_left - 1'b1;
                    end
                    r_gap <= GW'(NOTE_GAP - 1);
                end
                ST_GAP: begin
                    if (r_gap != '0) r_gap <= r_gap - 1'b1;
                    // done lands in the first IDLE cycle after the last gap
                    r_done <= (r_gap == '0) && !w_more;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// ---------------------------------------------------------------------------
// tb_atm_cash_dispenser
// Directed scenarios plus randomized loads/requests, checked against a
// reservoir model that derives the expected pulse schedule arithmetically.
// ---------------------------------------------------------------------------
module tb_atm_cash_dispenser;

    localparam int AMT_W = 16;
    localparam int CNT_W = 8;
    localparam int NB    = 10;
    localparam int NS    = 1;
    localparam int GAP   = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             load_valid;
    logic [CNT_W-1:0] load_big, load_small;
    logic             note_big, note_small, done, not_enough_cash, busy;
    logic [AMT_W-1:0] cash_total;

    int checks = 0;
    int errors = 0;
    int m_big  = 0;
    int m_small = 0;

    atm_cash_dispenser #(
        .AMT_W(AMT_W), .CNT_W(CNT_W), .NOTE_BIG(NB), .NOTE_SMALL(NS), .NOTE_GAP(GAP)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
        .load_valid(load_valid), .load_big(load_big), .load_small(load_small),
        .note_big(note_big), .note_small(note_small), .done(done),
        .not_enough_cash(not_enough_cash), .busy(busy), .cash_total(cash_total)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic int model_total();
        return (m_big * NB + m_small * NS) % (1 << AMT_W);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        m_big = 0;
        m_small = 0;
    endtask

    // Refill while idle; model saturates each count independently.
    task automatic do_load(input int lb, input int ls);
        load_valid = 1'b1;
        load_big   = CNT_W'(lb);
        load_small = CNT_W'(ls);
        @(posedge clock); #1;
        load_valid = 1'b0;
        m_big   = sat(m_big + lb);
        m_small = sat(m_small + ls);
        @(negedge clock);
        chk("load_total", cash_total, model_total());
    endtask

    // One withdrawal. Cycle c counts from the handshake edge T (c=1 is T+1).
    task automatic do_req(input int amt, input bit with_load, input int lb, input int ls,
                          input bit noise);
        int  ub, rem, n, c_end, k, idx;
        bit  ok, slot;
        chk("ready_before", req_ready, 1);
        req_valid  = 1'b1;
        req_amount = AMT_W'(amt);
        if (with_load) begin
            load_valid = 1'b1;
            load_big   = CNT_W'(lb);
            load_small = CNT_W'(ls);
            m_big   = sat(m_big + lb);
            m_small = sat(m_small + ls);
        end
        ub    = (amt / NB < m_big) ? amt / NB : m_big;
        rem   = amt - ub * NB;
        ok    = (amt != 0) && (rem % NS == 0) && (rem / NS <= m_small);
        n     = ub + rem / NS;
        c_end = ok ? 2 + n * (1 + GAP) : 2;
        @(posedge clock); #1;
        req_valid  = 1'b0;
        load_valid = 1'b0;
        for (int c = 1; c <= c_end; c++) begin
            if (noise && c < c_end) begin
                load_valid = 1'b1;
                load_big   = CNT_W'($urandom_range(1, 50));
                load_small = CNT_W'($urandom_range(1, 50));
            end else begin
                load_valid = 1'b0;
            end
            @(negedge clock);
            k    = c - 2;
            idx  = (k >= 0) ? k / (1 + GAP) : 0;
            slot = ok && (k >= 0) && (k % (1 + GAP) == 0) && (idx < n);
            chk($sformatf("note_big a=%0d c=%0d", amt, c), note_big, slot && idx < ub);
            chk($sformatf("note_small a=%0d c=%0d", amt, c), note_small, slot && idx >= ub);
            chk($sformatf("done a=%0d c=%0d", amt, c), done, ok && c == c_end);
            chk($sformatf("nec a=%0d c=%0d", amt, c), not_enough_cash, !ok && c == 2);
            chk($sformatf("busy a=%0d c=%0d", amt, c), busy, c < c_end);
            if (c < c_end) begin
                @(posedge clock); #1;
            end
        end
        load_valid = 1'b0;
        if (ok) begin
            m_big   -= ub;
            m_small -= rem / NS;
        end
        chk($sformatf("total_after a=%0d", amt), cash_total, model_total());
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_amount = '0;
        load_valid = 1'b0; load_big = '0; load_small = '0;
        @(negedge clock);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_total", cash_total, 0);
        chk("rst_pulses", {note_big, note_small, done, not_enough_cash}, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Reset mid-payout of a 30 request
        do_load(3, 0);
        req_valid = 1'b1; req_amount = 16'd30;
        @(posedge clock); #1; req_valid = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("pay_before_reset", note_big, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_note", note_big, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_total", cash_total, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        m_big = 0; m_small = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            chk("no_done_after_reset", {done, note_big, note_small}, 0);
        end

        // Reject, then small payout
        do_load(9, 10);
        chk("total_100", cash_total, 100);
        do_req(110, 0, 0, 0, 0);
        do_req(2, 0, 0, 0, 0);
        chk("total_98", cash_total, 98);

        // Mixed payout: 2 big then 5 small
        do_reset();
        do_load(2, 10);
        do_req(25, 0, 0, 0, 0);
        chk("total_5", cash_total, 5);

        // Small short, zero amount
        do_reset();
        do_load(0, 3);
        do_req(10, 0, 0, 0, 0);
        do_req(0, 0, 0, 0, 0);

        // Load with request in same cycle, then loads during payout
        do_req(10, 1, 1, 0, 0);
        chk("total_3", cash_total, 3);
        do_req(3, 0, 0, 0, 1);
        chk("total_0", cash_total, 0);

        // Saturation
        do_load(200, 200);
        do_load(100, 100);
        chk("sat_total", cash_total, CMAX * NB + CMAX * NS);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_load($urandom_range(0, 4), $urandom_range(0, 15));
            do_req($urandom_range(0, 60), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 10), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
